core_dbus_wb_bridge: RTL and testbench

- Responder for the core's data-memory port (mem_addr_mem, mem_wdata_mem, mem_write_mem, mem_op_mem, mem_read_mem, mem_rdata_mem, stall_pipl).
- Turns each core load/store into one Wishbone classic master cycle, holding the pipeline via stall_pipl until the access completes.
- Performs byte-lane steering and select generation for stores, and lane extraction with sign/zero extension for loads.
- Sits between the core top and the SoC Wishbone interconnect.

---
 rtl/core_dbus_wb_bridge.sv | 124 ++++++++++++
 tb/tb_core_dbus_wb_bridge.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/core_dbus_wb_bridge.sv
// core_dbus_wb_bridge: core data-port to Wishbone classic master, one bus cycle per load/store
module core_dbus_wb_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] mem_addr_mem,
  input  logic [31:0] mem_wdata_mem,
  input  logic        mem_write_mem,
  input  logic        mem_read_mem,
  input  logic [2:0]  mem_op_mem,
  output logic [31:0] mem_rdata_mem,
  output logic        stall_pipl,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        bus_fault
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_d;
  logic [31:0] cnt, cnt_d, adr_d, dat_d, rdata_d, st_data, shifted, ld_data;
  logic [3:0] sel_d, st_sel;
  logic [2:0] op, op_d;
  logic [1:0] lo, lo_d;
  logic we_d, cyc_d, stb_d, fault_d, req, misaligned, abort;
  assign req = mem_read_mem | mem_write_mem;
  assign stall_pipl = (state == IDLE && req) || state == BUSY;
  // size comes from op[1:0]; undefined ops fall into the word case
  assign misaligned = (mem_op_mem[1:0] == 2'b01 && mem_addr_mem[0]) ||
                      (mem_op_mem[1] && mem_addr_mem[1:0] != 2'b00);
  assign st_sel = mem_op_mem[1:0] == 2'b00 ? 4'b0001 << mem_addr_mem[1:0] :
                  mem_op_mem[1:0] == 2'b01 ? (mem_addr_mem[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign st_data = mem_op_mem[1:0] == 2'b00 ? {4{mem_wdata_mem[7:0]}} :
                   mem_op_mem[1:0] == 2'b01 ? {2{mem_wdata_mem[15:0]}} : mem_wdata_mem;
  assign shifted = wb_dat_i >> {lo, 3'b000};
  assign ld_data = op == 3'b000 ? {{24{shifted[7]}}, shifted[7:0]} :
                   op == 3'b001 ? {{16{shifted[15]}}, shifted[15:0]} :
                   op == 3'b100 ? {24'h0, shifted[7:0]} :
                   op == 3'b101 ? {16'h0, shifted[15:0]} : wb_dat_i;
  // cnt counts completed wait cycles, so the abort lands on the TIMEOUT_CYCLES-th one
  assign abort = wb_err_i || (TIMEOUT_CYCLES != 0 && cnt + 32'd1 == TIMEOUT_CYCLES);
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    op_d = op;
    lo_d = lo;
    adr_d = wb_adr_o;
    dat_d = wb_dat_o;
    sel_d = wb_sel_o;
    we_d = wb_we_o;
    cyc_d = wb_cyc_o;
    stb_d = wb_stb_o;
    rdata_d = mem_rdata_mem;
    fault_d = 1'b0;
    case (state)
      IDLE: if (req) begin
        if (misaligned) begin
          state_d = DONE;
          rdata_d = ERR_RDATA;
          fault_d = 1'b1;
        end else begin
          state_d = BUSY;
          cnt_d = '0;
          op_d = mem_op_mem;
          lo_d = mem_addr_mem[1:0];
          adr_d = {mem_addr_mem[31:2], 2'b00};
          dat_d = st_data;
          sel_d = st_sel;
          we_d = mem_write_mem;
          cyc_d = 1'b1;
          stb_d = 1'b1;
        end
      end
      BUSY: if (abort) begin
        state_d = DONE;
        cyc_d = 1'b0;
        stb_d = 1'b0;
        rdata_d = ERR_RDATA;
        fault_d = 1'b1;
      end else if (wb_ack_i) begin
        state_d = DONE;
        cyc_d = 1'b0;
        stb_d = 1'b0;
        rdata_d = wb_we_o ? mem_rdata_mem : ld_data;
      end else cnt_d = cnt + 32'd1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      op <= '0;
      lo <= '0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_sel_o <= '0;
      wb_we_o <= 1'b0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      mem_rdata_mem <= '0;
      bus_fault <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      op <= op_d;
      lo <= lo_d;
      wb_adr_o <= adr_d;
      wb_dat_o <= dat_d;
      wb_sel_o <= sel_d;
      wb_we_o <= we_d;
      wb_cyc_o <= cyc_d;
      wb_stb_o <= stb_d;
      mem_rdata_mem <= rdata_d;
      bus_fault <= fault_d;
    end
endmodule

// File: tb/tb_core_dbus_wb_bridge.sv
// tb_core_dbus_wb_bridge: directed scoreboard bench for the data-port Wishbone bridge
module tb_core_dbus_wb_bridge;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [31:0] mem_addr_mem = '0, mem_wdata_mem = '0, wb_dat_i = '0;
  logic mem_write_mem = 1'b0, mem_read_mem = 1'b0, wb_ack_i = 1'b0, wb_err_i = 1'b0;
  logic [2:0] mem_op_mem = '0;
  logic [31:0] mem_rdata_mem, wb_adr_o, wb_dat_o;
  logic [3:0] wb_sel_o;
  logic stall_pipl, wb_we_o, wb_cyc_o, wb_stb_o, bus_fault;
  int checks = 0, failures = 0;
  logic [31:0] last_rdata = '0;
  typedef struct {
    logic [31:0] adr, dat, rdata;
    logic [3:0] sel;
    logic we, fault;
    int cyc;
  } exp_t;
  exp_t sb[$];

  core_dbus_wb_bridge #(.TIMEOUT_CYCLES(4), .ERR_RDATA(ERR)) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_addr_mem(mem_addr_mem), .mem_wdata_mem(mem_wdata_mem),
    .mem_write_mem(mem_write_mem), .mem_read_mem(mem_read_mem), .mem_op_mem(mem_op_mem),
    .mem_rdata_mem(mem_rdata_mem), .stall_pipl(stall_pipl),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .bus_fault(bus_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] msel(input logic [2:0] op, input logic [1:0] a);
    case (op)
      3'b000, 3'b100: return 4'b0001 << a;
      3'b001, 3'b101: return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic mmis(input logic [2:0] op, input logic [1:0] a);
    case (op)
      3'b000, 3'b100: return 1'b0;
      3'b001, 3'b101: return a[0];
      default: return a != 2'b00;
    endcase
  endfunction

  function automatic logic [31:0] mdat(input logic [2:0] op, input logic [31:0] d);
    case (op)
      3'b000, 3'b100: return {4{d[7:0]}};
      3'b001, 3'b101: return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] mload(input logic [2:0] op, input logic [1:0] a, input logic [31:0] di);
    logic [7:0] b[4];
    logic [7:0] b0, b1;
    for (int i = 0; i < 4; i++) b[i] = di[8*i +: 8];
    b0 = b[a];
    b1 = b[{a[1], 1'b1}];
    case (op)
      3'b000: return {{24{b0[7]}}, b0};
      3'b100: return {24'h0, b0};
      3'b001: return {{16{b1[7]}}, b1, b0};
      3'b101: return {16'h0, b1, b0};
      default: return di;
    endcase
  endfunction

  // mode 0: ack after lat cycles, 1: err+ack after lat cycles, 2: never respond
  task automatic access(input logic w, input logic [2:0] op, input logic [31:0] a, d, di,
                        input int lat, input int mode);
    exp_t e, got;
    int busy_n = 0, stall_n = 0;
    logic done = 1'b0;
    logic mis;
    mis = mmis(op, a[1:0]);
    mem_addr_mem = a;
    mem_wdata_mem = d;
    mem_write_mem = w;
    mem_read_mem = !w;
    mem_op_mem = op;
    wb_dat_i = di;
    e.adr = {a[31:2], 2'b00};
    e.sel = msel(op, a[1:0]);
    e.dat = mdat(op, d);
    e.we = w;
    e.cyc = mis ? 0 : (mode == 2 ? 4 : lat);
    e.fault = mis || mode != 0;
    e.rdata = e.fault ? ERR : (w ? last_rdata : mload(op, a[1:0], di));
    last_rdata = e.rdata;
    sb.push_back(e);
    #1 stall_n = int'(stall_pipl);
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (wb_cyc_o) begin
        busy_n++;
        stall_n += int'(stall_pipl);
        chk("busy_stall", stall_pipl, 1'b1);
        chk("busy_stb", wb_stb_o, 1'b1);
        chk("busy_adr", wb_adr_o, e.adr);
        chk("busy_sel", wb_sel_o, e.sel);
        chk("busy_we", wb_we_o, e.we);
        if (w) chk("busy_dat", wb_dat_o, e.dat);
        wb_ack_i = busy_n == lat && mode != 2;
        wb_err_i = busy_n == lat && mode == 1;
      end else if (!stall_pipl) begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        done = 1'b1;
        got = sb.pop_front();
        chk("rdata", mem_rdata_mem, got.rdata);
        chk("bus_fault", bus_fault, got.fault);
        chk("cyc_cycles", busy_n, got.cyc);
        chk("stall_cycles", stall_n, got.cyc + 1);
      end else stall_n++;
    end
    chk("done_reached", done, 1'b1);
  endtask

  task automatic idle();
    mem_read_mem = 1'b0;
    mem_write_mem = 1'b0;
    @(negedge clk);
    chk("idle_fault_clear", bus_fault, 1'b0);
    chk("idle_stall", stall_pipl, 1'b0);
    chk("idle_cyc", wb_cyc_o, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_cyc", wb_cyc_o, 1'b0);
    chk("rst_stb", wb_stb_o, 1'b0);
    chk("rst_rdata", mem_rdata_mem, 32'h0);
    chk("rst_sel", wb_sel_o, 4'h0);
    chk("rst_stall", stall_pipl, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);
    access(1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hCAFE_BABE, 2, 0);
    idle();
    access(1'b1, 3'b000, 32'h0000_0203, 32'h0000_00A5, 32'h0, 1, 0);
    idle();
    access(1'b0, 3'b000, 32'h0000_0102, 32'h0, 32'h0080_0000, 1, 0);
    idle();
    access(1'b0, 3'b100, 32'h0000_0102, 32'h0, 32'h0080_0000, 1, 0);
    idle();
    access(1'b0, 3'b101, 32'h0000_0102, 32'h0, 32'h8001_1234, 1, 0);
    idle();
    access(1'b0, 3'b001, 32'h0000_0101, 32'h0, 32'h0, 1, 0);
    idle();
    access(1'b0, 3'b010, 32'h0000_0104, 32'h0, 32'h1111_2222, 0, 2);
    idle();
    access(1'b0, 3'b010, 32'h0000_0108, 32'h0, 32'h3333_4444, 1, 1);
    idle();
    access(1'b1, 3'b001, 32'h0000_0106, 32'h0000_1234, 32'h0, 1, 0);
    access(1'b0, 3'b001, 32'h0000_010A, 32'h0, 32'hF00D_0000, 1, 0);
    access(1'b1, 3'b010, 32'h0000_010C, 32'h1122_3344, 32'h0, 3, 0);
    access(1'b0, 3'b010, 32'h0000_0110, 32'h0, 32'h7654_3210, 1, 0);
    idle();
    access(1'b0, 3'b111, 32'h0000_0102, 32'h0, 32'h0, 1, 0);
    idle();
    access(1'b0, 3'b011, 32'h0000_0114, 32'h0, 32'h5555_AAAA, 2, 0);
    idle();
    mem_addr_mem = 32'h0000_0300;
    mem_wdata_mem = 32'h1234_5678;
    mem_op_mem = 3'b010;
    mem_read_mem = 1'b1;
    @(negedge clk);
    chk("rstmid_cyc_before", wb_cyc_o, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("rstmid_cyc", wb_cyc_o, 1'b0);
    chk("rstmid_stb", wb_stb_o, 1'b0);
    chk("rstmid_adr", wb_adr_o, 32'h0);
    chk("rstmid_dat", wb_dat_o, 32'h0);
    chk("rstmid_sel", wb_sel_o, 4'h0);
    chk("rstmid_rdata", mem_rdata_mem, 32'h0);
    chk("rstmid_stall_idle", stall_pipl, 1'b1);
    mem_read_mem = 1'b0;
    #1 chk("rstmid_stall_low", stall_pipl, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    last_rdata = 32'h0;
    @(negedge clk);
    access(1'b1, 3'b000, 32'h0000_0401, 32'h0000_003C, 32'h0, 1, 0);
    idle();
    access(1'b0, 3'b010, 32'h0000_0400, 32'h0, 32'h0000_3C00, 1, 0);
    idle();
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
